// File: rtl/vedic_pkg.sv
// vedic_pkg: shared state encoding and width helpers for the Vedic multiply-accumulate
package vedic_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FLUSH, DONE} state_t;
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int min(input int x, input int y);
    return (x < y) ? x : y;
  endfunction
  function automatic int ncol_f(input int a_w, input int b_w);
    return a_w + b_w - 1;
  endfunction
  function automatic int sum_w_f(input int a_w, input int b_w);
    return clog2(2 * min(a_w, b_w) + 3);
  endfunction
endpackage

// File: rtl/vedic_col_sum.sv
// vedic_col_sum: one Urdhva-Tiryagbhyam column sum, popcount of a[i]&b[j] with i+j==col plus c-bit and carry; ports a,b,col,c_bit,carry in, s out
module vedic_col_sum #(
  parameter int A_W   = 5,
  parameter int B_W   = 4,
  parameter int COL_W = 4,
  parameter int SUM_W = 4
) (
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [COL_W-1:0] col,
  input  logic             c_bit,
  input  logic [SUM_W-1:0] carry,
  output logic [SUM_W-1:0] s
);
  always_comb begin
    s = SUM_W'(c_bit) + carry;
    for (int i = 0; i < A_W; i++)
      for (int j = 0; j < B_W; j++)
        if (i + j == int'(col)) s = s + SUM_W'(a[i] & b[j]);
  end
endmodule

// File: rtl/vedic_mul_acc.sv
// vedic_mul_acc: sequential column-per-clock P=A*B+C with valid/ready; ports clk,rst,in_valid/in_ready/a_in/b_in/c_in,out_valid/out_ready/product,busy; optional VEDIC_MUL_ZERO_SKIP_EN
module vedic_mul_acc
  import vedic_pkg::*;
#(
  parameter int A_W = 5,
  parameter int B_W = 4,
  parameter int C_W = 3,
  parameter int P_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a_in,
  input  logic [B_W-1:0] b_in,
  input  logic [C_W-1:0] c_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] product,
  output logic           busy
);
  localparam int NCOL  = ncol_f(A_W, B_W);
  localparam int SUM_W = sum_w_f(A_W, B_W);
  localparam int COL_W = clog2(NCOL);
  state_t            state_q, state_d;
  logic [A_W-1:0]    a_q, a_d;
  logic [B_W-1:0]    b_q, b_d;
  logic [C_W-1:0]    c_q, c_d;
  logic [NCOL-1:0]   acc_q, acc_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [SUM_W-1:0]  carry_q, carry_d, s;
  logic [P_W-1:0]    product_q, product_d;
  // c is shifted right each column so its LSB is always the bit for the current column
  vedic_col_sum #(.A_W(A_W), .B_W(B_W), .COL_W(COL_W), .SUM_W(SUM_W)) u_col (
    .a(a_q), .b(b_q), .col(col_q), .c_bit(c_q[0]), .carry(carry_q), .s(s)
  );
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    acc_d     = acc_q;
    col_d     = col_q;
    carry_d   = carry_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a_in;
        b_d     = b_in;
        c_d     = c_in;
        acc_d   = '0;
        col_d   = '0;
        carry_d = '0;
        state_d = CALC;
`ifdef VEDIC_MUL_ZERO_SKIP_EN
        if (a_in == '0 || b_in == '0) begin
          product_d = P_W'(c_in);
          state_d   = DONE;
        end
`endif
      end
      CALC: begin
        // result bits enter at the top and drift down, so column 0 lands in bit 0 after NCOL shifts
        acc_d   = {s[0], acc_q[NCOL-1:1]};
        carry_d = s >> 1;
        c_d     = c_q >> 1;
        col_d   = col_q + 1'b1;
        state_d = (col_q == COL_W'(NCOL - 1)) ? FLUSH : CALC;
      end
      FLUSH: begin
        product_d = {(P_W - NCOL)'(carry_q), acc_q};
        state_d   = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      acc_q     <= '0;
      col_q     <= '0;
      carry_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      acc_q     <= acc_d;
      col_q     <= col_d;
      carry_q   <= carry_d;
      product_q <= product_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == FLUSH);
  assign product   = product_q;
endmodule
